ysyx_22041752_clint: RTL

Core-local interruptor; the timer/software interrupt source that drives the CSR file's timer-interrupt input (int_t_i) and a software-interrupt line. It holds the 64-bit mtime counter, mtimecmp and msip. It exposes them through a single-outstanding valid/ready memory-mapped slave port on the LSU data path. The CSR file does the mstatus.MIE/mie gating; this block only raises raw pending levels.

---
 rtl/ysyx_22041752_clint.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ysyx_22041752_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding
// valid/ready slave port, raising raw timer and software interrupt levels.
module ysyx_22041752_clint #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              int_t_o,
  output logic              int_s_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = ADDR_W - 3;
  localparam logic [WW-1:0] MSIP_WA     = '0;
  localparam logic [WW-1:0] MTIMECMP_WA = WW'(32'h4000 >> 3);
  localparam logic [WW-1:0] MTIME_WA    = WW'(32'hBFF8 >> 3);

  logic [PW-1:0] prescaler;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic [WW-1:0] word_addr;
  logic          unused_addr_bits;
  logic          accept;
  logic          tick;
  logic          hit_msip;
  logic          hit_cmp;
  logic          hit_time;
  logic          wr_msip;
  logic          wr_cmp;
  logic          wr_time;
  logic [63:0]   read_data;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // The lowest three address bits select a byte within a doubleword and are ignored.
  assign word_addr        = req_addr[ADDR_W-1:3];
  assign unused_addr_bits = ^req_addr[2:0];

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign tick      = (prescaler == PW'(TICK_DIV - 1));

  assign hit_msip = (word_addr == MSIP_WA);
  assign hit_cmp  = (word_addr == MTIMECMP_WA);
  assign hit_time = (word_addr == MTIME_WA);

  assign wr_msip = accept && req_wen && hit_msip && req_wstrb[0];
  assign wr_cmp  = accept && req_wen && hit_cmp;
  assign wr_time = accept && req_wen && hit_time;

  always_comb begin
    read_data = '0;
    if (hit_msip)      read_data = {63'd0, msip};
    else if (hit_cmp)  read_data = mtimecmp;
    else if (hit_time) read_data = mtime;
  end

  // Free-running prescaler; an mtime write deliberately leaves its phase alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // A software write to mtime takes priority over that cycle's tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (wr_time)   mtime <= merge_bytes(mtime, req_wdata, req_wstrb);
      else if (tick) mtime <= mtime + 64'd1;
      if (wr_cmp)    mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wstrb);
      if (wr_msip)   msip <= req_wdata[0];
    end
  end

  // Response registers only change on accept, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_wen ? 64'd0 : read_data;
      rsp_err   <= !(hit_msip || hit_cmp || hit_time);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_t_o <= 1'b0;
      int_s_o <= 1'b0;
    end else begin
      int_t_o <= (mtime >= mtimecmp);
      int_s_o <= msip;
    end
  end

endmodule
